// File: rtl/spi_mem_master.sv
// SPI mode-0 master for one opcode/address/data frame per request; DONE lands (2N+2)*CLK_DIV edges after accept.
// Requests are taken only while ready_o=1 (no queueing); abort_i returns to IDLE on the next edge without done_o.
module spi_mem_master #(
  parameter int         ADDR_W  = 16,
  parameter int         DATA_W  = 16,
  parameter int         CLK_DIV = 2,
  parameter logic [7:0] CMD_RD  = 8'h03,
  parameter logic [7:0] CMD_WR  = 8'h02
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              abort_i,
  output logic              ready_o,
  output logic              done_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              sclk_o,
  output logic              csb_o,
  output logic              mo_o,
  input  logic              mi_i
);

  localparam int N = 8 + ADDR_W + DATA_W;

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        div_q, div_d;
  logic [6:0]        bit_q, bit_d;
  logic [N-1:0]      tx_q, tx_d;
  logic [DATA_W-1:0] rx_q, rx_d;
  logic [DATA_W-1:0] rdata_q, rdata_d;
  logic              we_q, we_d;
  logic              sclk_q, sclk_d;
  logic              csb_q, csb_d;
  logic              ready_q, ready_d;
  logic              done_q, done_d;
  logic              div_end;
  logic [7:0]        opcode;
  logic [DATA_W-1:0] wdata_sel;

  assign div_end   = (div_q == 8'(CLK_DIV - 1));
  assign opcode    = we_i ? CMD_WR : CMD_RD;
  assign wdata_sel = we_i ? wdata_i : {DATA_W{1'b0}};

  always_comb begin
    state_d = state_q;
    div_d   = div_q + 8'd1;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rdata_d = rdata_q;
    we_d    = we_q;
    sclk_d  = sclk_q;
    unique case (state_q)
      IDLE: begin
        div_d = 8'd0;
        if (req_i) begin
          state_d = SETUP;
          we_d    = we_i;
          tx_d    = {opcode, addr_i, wdata_sel};
        end
      end
      SETUP: begin
        if (div_end) begin
          state_d = SHIFT;
          div_d   = 8'd0;
          bit_d   = 7'd0;
          sclk_d  = 1'b1;
          rx_d    = {rx_q[DATA_W-2:0], mi_i};
        end
      end
      SHIFT: begin
        if (div_end) begin
          div_d = 8'd0;
          if (sclk_q) begin
            // falling edge: present the next frame bit
            sclk_d = 1'b0;
            tx_d   = {tx_q[N-2:0], 1'b0};
          end else if (bit_q == 7'(N - 1)) begin
            state_d = HOLD;
          end else begin
            bit_d  = bit_q + 7'd1;
            sclk_d = 1'b1;
            rx_d   = {rx_q[DATA_W-2:0], mi_i};
          end
        end
      end
      HOLD: begin
        if (div_end) begin
          state_d = DONE;
          if (!we_q) rdata_d = rx_q;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_i && (state_q != IDLE)) begin
      state_d = IDLE;
      sclk_d  = 1'b0;
      tx_d    = '0;
    end
  end

  // Output flops are loaded from the next state so every pin is a register.
  assign ready_d = (state_d == IDLE);
  assign done_d  = (state_d == DONE);
  assign csb_d   = (state_d == IDLE) || (state_d == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      div_q   <= 8'd0;
      bit_q   <= 7'd0;
      tx_q    <= '0;
      rx_q    <= '0;
      rdata_q <= '0;
      we_q    <= 1'b0;
      sclk_q  <= 1'b0;
      csb_q   <= 1'b1;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rdata_q <= rdata_d;
      we_q    <= we_d;
      sclk_q  <= sclk_d;
      csb_q   <= csb_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign ready_o = ready_q;
  assign done_o  = done_q;
  assign rdata_o = rdata_q;
  assign sclk_o  = sclk_q;
  assign csb_o   = csb_q;
  assign mo_o    = tx_q[N-1];

endmodule

// File: tb/tb_spi_mem_master.sv
// Bench for spi_mem_master: default build plus a 24/8/CLK_DIV=1 build, driven one at a time through sel.
module tb_spi_mem_master;
  localparam int NB = 40;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n = 1'b0;
  logic        req = 1'b0, we = 1'b0, abort = 1'b0, mi = 1'b0, sel = 1'b0;
  logic [23:0] addr = '0;
  logic [15:0] wdata = '0;

  logic ready_a, done_a, sclk_a, csb_a, mo_a;
  logic [15:0] rdata_a;
  logic ready_b, done_b, sclk_b, csb_b, mo_b;
  logic [7:0] rdata_b;

  spi_mem_master u_a (
    .clk(clk), .rst_n(rst_n), .req_i(req & ~sel), .we_i(we), .addr_i(addr[15:0]),
    .wdata_i(wdata), .abort_i(abort & ~sel), .ready_o(ready_a), .done_o(done_a),
    .rdata_o(rdata_a), .sclk_o(sclk_a), .csb_o(csb_a), .mo_o(mo_a), .mi_i(mi)
  );

  spi_mem_master #(.ADDR_W(24), .DATA_W(8), .CLK_DIV(1)) u_b (
    .clk(clk), .rst_n(rst_n), .req_i(req & sel), .we_i(we), .addr_i(addr),
    .wdata_i(wdata[7:0]), .abort_i(abort & sel), .ready_o(ready_b), .done_o(done_b),
    .rdata_o(rdata_b), .sclk_o(sclk_b), .csb_o(csb_b), .mo_o(mo_b), .mi_i(mi)
  );

  logic ready, done, sclk, csb, mo;
  logic [15:0] rdata;
  always_comb begin
    ready = sel ? ready_b : ready_a;
    done  = sel ? done_b  : done_a;
    sclk  = sel ? sclk_b  : sclk_a;
    csb   = sel ? csb_b   : csb_a;
    mo    = sel ? mo_b    : mo_a;
    rdata = sel ? {8'h00, rdata_b} : rdata_a;
  end

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // transaction model
  bit          busy = 1'b0;
  int          t0 = 0;
  bit          m_we = 1'b0;
  logic [23:0] m_addr = '0;
  logic [15:0] m_wdata = '0;
  logic [15:0] resp_data = '0;
  logic [39:0] resp_word = '1;
  logic [39:0] exp_frame = '0;
  logic [15:0] m_rdata [2];
  logic [15:0] mem [int];

  // bus observer / slave state
  bit          prev_sclk = 1'b0, prev_csb = 1'b1;
  logic [39:0] cap = '0, last_frame = '0;
  int          rises = 0, last_rises = 0, fidx = 0, gap = 0, falls = 0, dones = 0;

  function automatic int dval();
    return sel ? 1 : 2;
  endfunction

  function automatic int key(input logic s, input logic [23:0] a);
    return {7'd0, s, a};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic model_edge();
    int k, tt;
    logic [7:0] op;
    if (!rst_n) begin
      busy = 1'b0;
      m_rdata[0] = '0;
      m_rdata[1] = '0;
    end else if (busy) begin
      k  = cyc - t0;
      tt = (2 * NB + 2) * dval();
      if (k == tt + 1) busy = 1'b0;
      else if (abort) busy = 1'b0;
      else if (k == tt) begin
        if (m_we) mem[key(sel, m_addr)] = m_wdata;
        else m_rdata[sel] = resp_data;
      end
    end else if (req) begin
      busy    = 1'b1;
      t0      = cyc;
      m_we    = we;
      m_addr  = sel ? addr : {8'h00, addr[15:0]};
      m_wdata = sel ? {8'h00, wdata[7:0]} : wdata;
      resp_data = mem.exists(key(sel, m_addr)) ? mem[key(sel, m_addr)] : 16'h0000;
      op = we ? 8'h02 : 8'h03;
      if (sel) begin
        exp_frame = {op, m_addr, (we ? m_wdata[7:0] : 8'h00)};
        resp_word = we ? '1 : {32'hFFFF_FFFF, resp_data[7:0]};
      end else begin
        exp_frame = {op, m_addr[15:0], (we ? m_wdata : 16'h0000)};
        resp_word = we ? '1 : {24'hFF_FFFF, resp_data};
      end
    end
  endtask

  task automatic monitor();
    int k, tt, d;
    bit e_csb, e_sclk, e_done, e_ready;
    if (!rst_n) begin
      chk("rst_csb", csb, 1);
      chk("rst_sclk", sclk, 0);
      chk("rst_ready", ready, 1);
      chk("rst_done", done, 0);
      chk("rst_mo", mo, 0);
      chk("rst_rdata", rdata, 0);
      cap = '0; rises = 0; fidx = 0; mi = 1'b0;
      prev_sclk = 1'b0; prev_csb = 1'b1;
      return;
    end
    // SPI slave: present bit fidx, advance on each falling SCLK
    if (prev_csb && !csb) begin
      chk("cs_gap_min2", (gap >= 2), 1);
      falls++;
      cap = '0; rises = 0; fidx = 0;
      mi = resp_word[NB-1];
    end
    if (!prev_sclk && sclk) begin
      cap = {cap[38:0], mo};
      rises++;
    end
    if (prev_sclk && !sclk) begin
      fidx++;
      mi = (fidx < NB) ? resp_word[NB-1-fidx] : 1'b0;
    end
    gap = csb ? gap + 1 : 0;

    e_csb = 1'b1; e_sclk = 1'b0; e_done = 1'b0; e_ready = 1'b1;
    if (busy) begin
      d  = dval();
      k  = cyc - t0;
      tt = (2 * NB + 2) * d;
      e_csb   = (k >= tt);
      e_sclk  = (k >= d) && (k < (2 * NB + 1) * d) && ((((k - d) / d) % 2) == 0);
      e_done  = (k == tt);
      e_ready = 1'b0;
    end
    chk("csb", csb, e_csb);
    chk("sclk", sclk, e_sclk);
    chk("done", done, e_done);
    chk("ready", ready, e_ready);
    chk("rdata", rdata, m_rdata[sel]);
    if (!busy) chk("idle_mo", mo, 0);
    if (done) begin
      dones++;
      last_frame = cap;
      last_rises = rises;
      if (busy) begin
        chk("frame", cap, exp_frame);
        chk("sclk_rises", rises, NB);
      end
    end
    prev_sclk = sclk;
    prev_csb  = csb;
  endtask

  task automatic start(input bit w, input logic [23:0] a, input logic [15:0] dat, output int e0);
    int n = 0;
    while (ready !== 1'b1 && n < 500) begin @(negedge clk); n++; end
    chk("ready_wait", (n < 500), 1);
    we = w; addr = a; wdata = dat; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    e0 = cyc;
  endtask

  task automatic wait_done(input string nm);
    int n = 0;
    while (done !== 1'b1 && n < 2000) begin @(negedge clk); n++; end
    chk(nm, done, 1);
  endtask

  initial begin
    int e0, k, f0, d0;
    m_rdata[0] = '0;
    m_rdata[1] = '0;
    fork
      forever begin @(posedge clk); cyc++; model_edge(); end
      forever begin @(negedge clk); monitor(); end
    join_none

    repeat (3) @(negedge clk);
    chk("reset_ready", ready, 1);
    chk("reset_csb", csb, 1);
    chk("reset_rdata", rdata, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // read on the default build
    mem[key(1'b0, 24'h001234)] = 16'hBEEF;
    start(1'b0, 24'h001234, 16'h0000, e0);
    wait_done("rd_done_seen");
    k = cyc - e0;
    chk("rd_done_edge", k, 164);
    @(negedge clk);
    chk("rd_frame", last_frame, 40'h03_1234_0000);
    chk("rd_rises", last_rises, 40);
    chk("rd_data", rdata, 16'hBEEF);
    chk("rd_ready_after", ready, 1);

    // write; rdata must hold
    start(1'b1, 24'h0000FF, 16'hA55A, e0);
    wait_done("wr_done_seen");
    k = cyc - e0;
    chk("wr_done_edge", k, 164);
    @(negedge clk);
    chk("wr_frame", last_frame, 40'h02_00FF_A55A);
    chk("wr_rdata_kept", rdata, 16'hBEEF);

    // read back what the slave stored
    start(1'b0, 24'h0000FF, 16'h0000, e0);
    wait_done("rb_done_seen");
    @(negedge clk);
    chk("rb_data", rdata, 16'hA55A);

    // abort during bit 10 of a read
    d0 = dones;
    start(1'b0, 24'h001234, 16'h0000, e0);
    while (cyc - e0 < 38) @(negedge clk);
    chk("abort_bit10_sclk_high", sclk, 1);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk("abort_csb", csb, 1);
    chk("abort_sclk", sclk, 0);
    chk("abort_ready", ready, 1);
    repeat (200) @(negedge clk);
    chk("abort_no_done", dones - d0, 0);
    chk("abort_rdata_kept", rdata, 16'hA55A);
    start(1'b0, 24'h001234, 16'h0000, e0);
    wait_done("post_abort_done_seen");
    k = cyc - e0;
    chk("post_abort_done_edge", k, 164);
    @(negedge clk);
    chk("post_abort_data", rdata, 16'hBEEF);

    // req held high across two writes; inputs change after the first accept
    f0 = falls; d0 = dones;
    we = 1'b1; addr = 24'h000010; wdata = 16'h1111; req = 1'b1;
    @(negedge clk);
    addr = 24'h000020; wdata = 16'h2222;
    wait_done("hs1_done_seen");
    @(negedge clk);
    chk("hs1_frame", last_frame, 40'h02_0010_1111);
    wait_done("hs2_done_seen");
    req = 1'b0;
    @(negedge clk);
    chk("hs2_frame", last_frame, 40'h02_0020_2222);
    repeat (5) @(negedge clk);
    chk("hs_frames", falls - f0, 2);
    chk("hs_dones", dones - d0, 2);

    // req pulses while busy and during DONE are ignored
    f0 = falls;
    start(1'b0, 24'h000010, 16'h0000, e0);
    while (cyc - e0 < 50) @(negedge clk);
    addr = 24'h000077; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    wait_done("busy_done_seen");
    addr = 24'h000099; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    repeat (4) @(negedge clk);
    chk("busy_req_ignored", falls - f0, 1);
    chk("busy_rd_data", rdata, 16'h1111);

    // reset in the middle of SHIFT
    start(1'b0, 24'h000020, 16'h0000, e0);
    while (cyc - e0 < 60) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("midrst_csb", csb, 1);
    chk("midrst_sclk", sclk, 0);
    chk("midrst_ready", ready, 1);
    chk("midrst_rdata", rdata, 16'h0000);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // 24-bit address, 8-bit data, CLK_DIV=1 build
    sel = 1'b1;
    mem[key(1'b1, 24'hABCDEF)] = 16'h005C;
    @(negedge clk);
    start(1'b0, 24'hABCDEF, 16'h0000, e0);
    wait_done("sw_done_seen");
    k = cyc - e0;
    chk("sw_done_edge", k, 82);
    @(negedge clk);
    chk("sw_frame", last_frame, 40'h03_ABCDEF_00);
    chk("sw_rises", last_rises, 40);
    chk("sw_data", rdata, 16'h005C);
    start(1'b1, 24'h000123, 16'h0096, e0);
    wait_done("sw_wr_done_seen");
    @(negedge clk);
    chk("sw_wr_frame", last_frame, 40'h02_000123_96);
    chk("sw_wr_rdata_kept", rdata, 16'h005C);

    repeat (3) @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
